// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin burst arbiter:
// FSM state encoding, requester index constants and the rotating-priority pick.
package mux4_rr_arbiter_pkg;

  // Two-state arbiter FSM: IDLE arbitrates, BUSY carries one burst.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Requester indices, equal to the mux select value for each source.
  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;

  // Rotating priority: first set bit of valid searching ptr+1, ptr+2, ptr+3, ptr
  // (mod 4). The loop walks from lowest to highest priority so the last
  // assignment wins. Returns ptr when nothing is valid; the caller gates on |valid.
  function automatic logic [1:0] rr_pick(input logic [3:0] valid,
                                         input logic [1:0] ptr);
    logic [1:0] w_idx;
    logic [1:0] w_pick;
    w_pick = ptr;
    for (int k = 4; k >= 1; k--) begin
      w_idx = ptr + 2'(k);
      if (valid[w_idx]) begin
        w_pick = w_idx;
      end
    end
    return w_pick;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4x32.sv
// Plain 4:1 data multiplexer used as the shared datapath of the arbiter.
module mux4x32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Y
);

  // Select one of the four inputs; purely combinational.
  always_comb begin
    Y = A;
    case (S)
      2'd0:    Y = A;
      2'd1:    Y = B;
      2'd2:    Y = C;
      2'd3:    Y = D;
      default: Y = A;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst arbiter driving a shared 4:1 mux. A grant is held for a
// whole burst: until the owner's last beat or MAX_BEATS beats, whichever comes
// first. Every grant is followed by one IDLE cycle before the next arbitration.
//
// Handshake: a beat moves from the owner to the sink on a rising clk edge where
// out_valid and out_ready are both 1. out_valid mirrors the owner's req_valid
// while BUSY; req_ready of the owner mirrors out_ready while BUSY; every other
// req_ready bit is 0. Neither side may make its signal depend on seeing the
// other asserted first, and a valid beat holds its data until it transfers.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_valid,
  input  logic [3:0]       req_last,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [3:0]       grant,
  output logic             dbg_state
);

  // Counter is wide enough to hold MAX_BEATS-1 and is cleared on release,
  // so it never wraps.
  localparam int              CW        = $clog2(MAX_BEATS) + 1;
  localparam logic [CW-1:0]   LAST_BEAT = CW'(MAX_BEATS - 1);

  state_t        r_state;
  logic [1:0]    r_sel;
  logic [1:0]    r_ptr;
  logic [3:0]    r_grant;
  logic [CW-1:0] r_beat_cnt;

  logic          w_busy;
  logic          w_beat;
  logic          w_release;
  logic [1:0]    w_pick;

  assign w_busy    = (r_state == ST_BUSY);
  assign w_pick    = rr_pick(req_valid, r_ptr);

  assign out_valid = w_busy & req_valid[r_sel];
  assign out_last  = out_valid & req_last[r_sel];
  assign req_ready = w_busy ? ({3'b000, out_ready} << r_sel) : 4'b0000;

  // A beat ends the burst on the owner's last flag or on the beat limit;
  // both together still give a single release.
  assign w_beat    = out_valid & out_ready;
  assign w_release = w_beat & (req_last[r_sel] | (r_beat_cnt == LAST_BEAT));

  assign sel       = r_sel;
  assign grant     = r_grant;
  assign dbg_state = r_state;

  // Arbiter FSM: owner selection in IDLE, beat counting and release in BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= REQ_A;
      r_ptr      <= REQ_D;
      r_grant    <= 4'b0000;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_sel      <= w_pick;
            r_grant    <= 4'b0001 << w_pick;
            r_beat_cnt <= '0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            r_ptr      <= r_sel;
            r_beat_cnt <= '0;
            r_grant    <= 4'b0000;
            r_state    <= ST_IDLE;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  mux4x32 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .A(data_a),
    .B(data_b),
    .C(data_c),
    .D(data_d),
    .S(r_sel),
    .Y(out_data)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: a cycle-level model of the arbitration
// rules checked against the DUT on every falling edge, plus directed scenarios
// with hand-computed expectations.
module tb_mux4_rr_arbiter;

  localparam int WIDTH     = 32;
  localparam int MAX_BEATS = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       req_valid = 4'b0000;
  logic [3:0]       req_last  = 4'b0000;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] d [4];
  logic [3:0]       req_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       sel;
  logic [3:0]       grant;
  logic             dbg_state;

  mux4_rr_arbiter #(
    .WIDTH(WIDTH),
    .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_last(req_last),
    .data_a(d[0]),
    .data_b(d[1]),
    .data_c(d[2]),
    .data_d(d[3]),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready),
    .sel(sel),
    .grant(grant),
    .dbg_state(dbg_state)
  );

  // ---------------- check helper ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- data driver ----------------
  initial begin
    for (int i = 0; i < 4; i++) d[i] = 32'(i) * 32'h1111_1111;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) d[i] = $urandom;
    end
  end

  // ---------------- behavioural model + compare ----------------
  // Owner/pointer/beat count kept as plain integers; inputs are stable between
  // the falling edge and the next rising edge, so the model steps here.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_sel   = 0;
  int m_ptr   = 3;
  int m_beats = 0;

  always @(negedge clk) begin
    logic [3:0] e_grant;
    logic [3:0] e_ready;
    logic       e_valid;
    logic       e_last;
    bit         found;
    if (rst) begin
      m_busy = 1'b0; m_sel = 0; m_ptr = 3; m_beats = 0;
    end
    e_grant = m_busy ? 4'(1 << m_owner) : 4'b0000;
    e_valid = m_busy && req_valid[m_owner];
    e_ready = (m_busy && out_ready) ? 4'(1 << m_owner) : 4'b0000;
    e_last  = e_valid && req_last[m_owner];
    chk("grant", 64'(grant), 64'(e_grant));
    chk("sel", 64'(sel), 64'(m_sel));
    chk("out_valid", 64'(out_valid), 64'(e_valid));
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("out_last", 64'(out_last), 64'(e_last));
    chk("out_data", 64'(out_data), 64'(d[m_sel]));
    chk("state", 64'(dbg_state), 64'(m_busy));
    if (!rst) begin
      if (!m_busy) begin
        if (req_valid != 4'b0000) begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            if (!found && req_valid[(m_ptr + k) % 4]) begin
              m_owner = (m_ptr + k) % 4;
              found   = 1'b1;
            end
          end
          m_sel   = m_owner;
          m_busy  = 1'b1;
          m_beats = 0;
        end
      end else if (req_valid[m_owner] && out_ready) begin
        m_beats++;
        if (req_last[m_owner] || m_beats == MAX_BEATS) begin
          m_busy  = 1'b0;
          m_ptr   = m_owner;
          m_beats = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; req_valid = 4'b0000; req_last = 4'b0000; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  logic [3:0] g_exp [11];
  int xfers;

  initial begin
    g_exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
              4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

    // 1: single-beat burst from requester 0
    do_reset();
    for (int c = 0; c <= 2; c++) begin
      tick();
      if (c == 0) begin req_valid = 4'b0001; req_last = 4'b0001; out_ready = 1'b1; end
      if (c == 2) req_valid = 4'b0000;
      @(negedge clk);
      if (c == 0) chk("t1_idle_grant", 64'(grant), 64'h0);
      if (c == 1) begin
        chk("t1_grant", 64'(grant), 64'h1);
        chk("t1_sel", 64'(sel), 64'h0);
        chk("t1_out_last", 64'(out_last), 64'h1);
        chk("t1_out_data", 64'(out_data), 64'(d[0]));
      end
      if (c == 2) chk("t1_release", 64'(grant), 64'h0);
    end

    // 2: all four requesting, every beat last -> 0,1,2,3,0 with bubbles
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      tick();
      if (c == 0) begin req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1; end
      if (c == 10) req_valid = 4'b0000;
      @(negedge clk);
      chk($sformatf("t2_grant_c%0d", c), 64'(grant), 64'(g_exp[c]));
    end

    // 3: requester 2, four beats, out_ready toggling
    do_reset();
    xfers = 0;
    for (int c = 0; c <= 8; c++) begin
      tick();
      out_ready = (c % 2 == 1);
      req_valid = (c <= 7) ? 4'b0100 : 4'b0000;
      req_last  = (c == 7) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (out_valid && out_ready) xfers++;
      chk($sformatf("t3_ready_c%0d", c), 64'(req_ready),
          64'((c >= 1 && c <= 7 && c % 2 == 1) ? 4'b0100 : 4'b0000));
      if (c == 8) chk("t3_release", 64'(grant), 64'h0);
    end
    chk("t3_xfers", 64'(xfers), 64'd4);

    // 4: forced release after MAX_BEATS, waiting requester 3 wins next
    do_reset();
    xfers = 0;
    for (int c = 0; c <= 19; c++) begin
      tick();
      out_ready = 1'b1;
      req_valid = (c <= 18) ? 4'b1010 : 4'b0000;
      req_last  = (c == 18) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      if (out_valid && out_ready && sel == 2'd1) xfers++;
      if (c == 16) chk("t4_still_b", 64'(grant), 64'h2);
      if (c == 17) chk("t4_bubble", 64'(grant), 64'h0);
      if (c == 18) chk("t4_grant_d", 64'(grant), 64'h8);
      if (c == 19) chk("t4_release_d", 64'(grant), 64'h0);
    end
    chk("t4_b_beats", 64'(xfers), 64'd16);

    // 5: owner drops valid for three cycles mid-burst
    do_reset();
    xfers = 0;
    for (int c = 0; c <= 8; c++) begin
      tick();
      out_ready = 1'b1;
      req_valid = (c == 8 || (c >= 3 && c <= 5)) ? 4'b0000 : 4'b0001;
      req_last  = (c == 7) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      if (out_valid && out_ready) xfers++;
      if (c >= 3 && c <= 5) begin
        chk($sformatf("t5_hold_c%0d", c), 64'(grant), 64'h1);
        chk($sformatf("t5_novalid_c%0d", c), 64'(out_valid), 64'h0);
      end
      if (c == 7) chk("t5_last", 64'(out_last), 64'h1);
      if (c == 8) chk("t5_release", 64'(grant), 64'h0);
    end
    chk("t5_xfers", 64'(xfers), 64'd4);

    // 6: asynchronous reset mid-burst, then full request set starts at 0
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      tick();
      req_valid = 4'b0100; req_last = 4'b0000; out_ready = 1'b1;
      @(negedge clk);
    end
    chk("t6_busy_c", 64'(grant), 64'h4);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_grant", 64'(grant), 64'h0);
    chk("t6_rst_sel", 64'(sel), 64'h0);
    chk("t6_rst_valid", 64'(out_valid), 64'h0);
    chk("t6_rst_ready", 64'(req_ready), 64'h0);
    chk("t6_rst_last", 64'(out_last), 64'h0);
    req_valid = 4'b1111; req_last = 4'b1111;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_idle", 64'(grant), 64'h0);
    tick();
    @(negedge clk);
    chk("t6_first_a", 64'(grant), 64'h1);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t6_release", 64'(grant), 64'h0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
